// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier, WIDTH x WIDTH -> 2*WIDTH.
// The add/sub unit sits outside this block. Each CALC cycle this block drives
// the unit's Op/x/y, then takes its sum and overflow back in the same cycle.
// One Booth step is done per clock. Start/Busy/Done form the handshake
// toward the control unit.
module booth_mult_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ProdHi,
   output logic [WIDTH-1:0] ProdLo,
   output logic             AddOp,
   output logic [WIDTH-1:0] AddX,
   output logic [WIDTH-1:0] AddY,
   input  logic [WIDTH-1:0] AddSum,
   input  logic             AddOV
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_a;       // accumulator (upper half of the product)
   logic [WIDTH-1:0] r_q;       // multiplier, shifts into the lower half
   logic             r_q1;      // Booth history bit Q_-1
   logic [WIDTH-1:0] r_m;       // multiplicand
   logic [CNT_W-1:0] r_cnt;     // Booth step index
   logic [WIDTH-1:0] r_prod_hi;
   logic [WIDTH-1:0] r_prod_lo;

   logic             w_load;
   logic             w_last;
   logic             w_sgn;
   logic [WIDTH-1:0] w_a_next;
   logic [WIDTH-1:0] w_q_next;

   // Start is honoured only outside CALC, so a request during a multiply is dropped.
   assign w_load = (r_state != S_CALC) && Start;
   assign w_last = (r_state == S_CALC) && (r_cnt == CNT_W'(WIDTH - 1));

   // The add/sub result is really WIDTH+1 bits wide. Its true sign is the sum MSB
   // corrected by overflow. Without this, M = most-negative would shift in the wrong bit.
   assign w_sgn    = AddSum[WIDTH-1] ^ AddOV;
   assign w_a_next = {w_sgn, AddSum[WIDTH-1:1]};
   assign w_q_next = {AddSum[0], r_q[WIDTH-1:1]};

   // State register.
   always_ff @(posedge Clk) begin
      // NOTE: clocked state always uses non-blocking assignments. Every register then
      // samples pre-edge values, whatever the order of the statements.
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic: IDLE/DONE wait for Start; CALC runs WIDTH steps.
   always_comb begin
      // NOTE: default first, so every path assigns the signal and no latch is inferred.
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (Start) w_next_state = S_CALC;
         S_CALC:  if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = Start ? S_CALC : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Adder drive: select the Booth operation from {Q[0], Q_-1}; idle at zero outside CALC.
   always_comb begin
      AddOp = 1'b0;
      AddX  = '0;
      AddY  = '0;
      if (r_state == S_CALC) begin
         AddX = r_a;
         unique case ({r_q[0], r_q1})
            2'b01:   AddY = r_m;
            2'b10: begin
               AddOp = 1'b1;
               AddY  = r_m;
            end
            default: AddY = '0;
         endcase
      end
   end

   // Datapath: load operands, do one arithmetic shift per CALC cycle, capture the product on the final step.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_a       <= '0;
         r_q       <= '0;
         r_q1      <= 1'b0;
         r_m       <= '0;
         r_cnt     <= '0;
         r_prod_hi <= '0;
         r_prod_lo <= '0;
      end else if (w_load) begin
         r_m   <= A_in;
         r_q   <= B_in;
         r_a   <= '0;
         r_q1  <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == S_CALC) begin
         r_a   <= w_a_next;
         r_q   <= w_q_next;
         r_q1  <= r_q[0];
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_prod_hi <= w_a_next;
            r_prod_lo <= w_q_next;
         end
      end
   end

   assign Busy   = (r_state == S_CALC);
   assign Done   = (r_state == S_DONE);
   assign ProdHi = r_prod_hi;
   assign ProdLo = r_prod_lo;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq. A 16-bit signed add/sub unit is modelled inline.
// Products are checked against plain signed multiplication.
module tb_booth_mult_seq;

   localparam int W = 16;

   logic          Clk;
   logic          Rst;
   logic          Start;
   logic [W-1:0]  A_in;
   logic [W-1:0]  B_in;
   logic          Busy;
   logic          Done;
   logic [W-1:0]  ProdHi;
   logic [W-1:0]  ProdLo;
   logic          AddOp;
   logic [W-1:0]  AddX;
   logic [W-1:0]  AddY;
   logic [W-1:0]  AddSum;
   logic          AddOV;

   int total = 0;
   int bad   = 0;

   booth_mult_seq #(.WIDTH(W), .CNT_W(5)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .Start  (Start),
      .A_in   (A_in),
      .B_in   (B_in),
      .Busy   (Busy),
      .Done   (Done),
      .ProdHi (ProdHi),
      .ProdLo (ProdLo),
      .AddOp  (AddOp),
      .AddX   (AddX),
      .AddY   (AddY),
      .AddSum (AddSum),
      .AddOV  (AddOV)
   );

   // 16-bit signed add/sub unit: out = x +/- y, OV = signed overflow.
   assign AddSum = AddOp ? (AddX - AddY) : (AddX + AddY);
   assign AddOV  = AddOp ? ((AddX[W-1] != AddY[W-1]) && (AddSum[W-1] != AddX[W-1]))
                         : ((AddX[W-1] == AddY[W-1]) && (AddSum[W-1] != AddX[W-1]));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      return 32'(sa * sb);
   endfunction

   // Present operands with Start for one edge; afterwards the operands are scrambled (don't-care).
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      A_in  = a;
      B_in  = b;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      A_in  = W'($urandom);
      B_in  = W'($urandom);
   endtask

   // Count cycles until Done (bounded), and how many of them had Busy high.
   task automatic wait_done(output int cyc, output int busy_cyc);
      cyc      = 0;
      busy_cyc = 0;
      while (!Done && cyc < 40) begin
         if (Busy) busy_cyc++;
         tick();
         cyc++;
      end
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [31:0] exp);
      int cyc;
      int bc;
      start_op(a, b);
      wait_done(cyc, bc);
      check({tag, "_latency"}, cyc, 32'd16);
      check({tag, "_prod"}, {ProdHi, ProdLo}, exp);
   endtask

   initial begin
      int cyc;
      int bc;
      int done_seen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [31:0]  prev;

      Rst   = 1'b1;
      Start = 1'b0;
      A_in  = '0;
      B_in  = '0;
      tick();
      tick();

      // Reset state
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_prod", {ProdHi, ProdLo}, 32'd0);
      check("rst_adder", {15'd0, AddOp, AddX}, 32'd0);
      check("rst_addy", {16'd0, AddY}, 32'd0);
      Rst = 1'b0;
      tick();
      check("idle_busy", {31'd0, Busy}, 32'd0);

      // 3 x 5 with exact timing
      start_op(16'h0003, 16'h0005);
      check("b3x5_busy_after_load", {31'd0, Busy}, 32'd1);
      wait_done(cyc, bc);
      check("b3x5_latency", cyc, 32'd16);
      check("b3x5_busy_cycles", bc, 32'd16);
      check("b3x5_prod", {ProdHi, ProdLo}, 32'h0000_000F);
      check("b3x5_done_busy_low", {31'd0, Busy}, 32'd0);
      tick();
      check("b3x5_done_pulse", {31'd0, Done}, 32'd0);
      check("b3x5_idle_adder", {15'd0, AddOp, AddY}, 32'd0);
      check("b3x5_prod_hold", {ProdHi, ProdLo}, 32'h0000_000F);

      // Directed sign and boundary cases
      do_op("m3x5",   16'hFFFD, 16'h0005, 32'hFFFF_FFF1);
      do_op("5xm3",   16'h0005, 16'hFFFD, 32'hFFFF_FFF1);
      do_op("8k8k",   16'h8000, 16'h8000, 32'h4000_0000);
      do_op("8kx1",   16'h8000, 16'h0001, 32'hFFFF_8000);
      do_op("7f7f",   16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
      do_op("0x8k",   16'h0000, 16'h8000, 32'h0000_0000);
      do_op("1x8k",   16'h0001, 16'h8000, 32'hFFFF_8000);

      // Start during CALC is ignored, and the previous product holds meanwhile.
      tick();
      prev = {ProdHi, ProdLo};
      start_op(16'h1234, 16'h0056);
      repeat (4) tick();
      A_in  = 16'h0007;
      B_in  = 16'h0009;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("midstart_busy", {31'd0, Busy}, 32'd1);
      check("midstart_prod_stable", {ProdHi, ProdLo}, prev);
      wait_done(cyc, bc);
      check("midstart_latency", cyc, 32'd11);
      check("midstart_prod", {ProdHi, ProdLo}, 32'h0006_1D78);

      // Start held in the DONE cycle: next op loads with no IDLE gap.
      start_op(16'h0003, 16'h0005);
      check("b2b_busy", {31'd0, Busy}, 32'd1);
      wait_done(cyc, bc);
      check("b2b_latency", cyc, 32'd16);
      check("b2b_prod", {ProdHi, ProdLo}, 32'h0000_000F);

      // Reset at CALC cycle 8 abandons the op with no Done and clears the outputs.
      start_op(16'h1111, 16'h2222);
      repeat (7) tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      check("midrst_busy", {31'd0, Busy}, 32'd0);
      check("midrst_done", {31'd0, Done}, 32'd0);
      check("midrst_prod", {ProdHi, ProdLo}, 32'd0);
      check("midrst_adder", {15'd0, AddOp, AddX}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (Done) done_seen++;
         tick();
      end
      check("midrst_no_done", done_seen, 32'd0);
      do_op("after_rst", 16'hFFFF, 16'h7FFF, ref_prod(16'hFFFF, 16'h7FFF));

      // Random signed pairs against the arithmetic reference.
      for (int n = 0; n < 2000; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (n % 8 == 0) ra = 16'h8000;
         do_op("rand", ra, rb, ref_prod(ra, rb));
         if ($urandom_range(0, 1) == 0) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
